// File: rtl/slink_txn_arbiter.sv
// Round-robin grant arbiter for virtual AXI requesters sharing one serial link, with
// per-port and global outstanding caps and a drain mode. Grant statistics exist only
// when SLINK_ARB_STATS_EN is defined; otherwise grant_cnt_o is tied to zero.
module slink_txn_arbiter #(
   parameter int NumPorts       = 4,
   parameter int MaxTxnsPerPort = 4,
   parameter int MaxTxns        = 8,
   localparam int IdxW          = (NumPorts > 1) ? $clog2(NumPorts) : 1,
   localparam int CntW          = $clog2(MaxTxns + 1)
) (
   input  logic                          clk_i,
   input  logic                          rst_ni,
   input  logic [NumPorts-1:0]           req_valid_i,
   input  logic [NumPorts-1:0]           req_write_i,
   output logic [NumPorts-1:0]           req_ready_o,
   output logic                          gnt_valid_o,
   output logic [IdxW-1:0]               gnt_idx_o,
   output logic                          gnt_write_o,
   input  logic                          gnt_ready_i,
   input  logic                          cpl_valid_i,
   input  logic [IdxW-1:0]               cpl_idx_i,
   input  logic                          drain_i,
   output logic                          drained_o,
   output logic                          err_o,
   output logic [NumPorts-1:0][31:0]     grant_cnt_o
);

   typedef enum logic [1:0] {IDLE, HOLD, DRAIN} state_e;

   state_e              state_q;
   logic [IdxW-1:0]     rr_q;
   logic                gnt_valid_q;
   logic [IdxW-1:0]     gnt_idx_q;
   logic                gnt_write_q;
   logic                err_q;
   logic [CntW-1:0]     cnt_q [NumPorts];
   logic [CntW-1:0]     cnt_d [NumPorts];
   logic [CntW-1:0]     total_q;
   logic [CntW-1:0]     total_d;

   logic [NumPorts-1:0] elig;
   logic                sel_found;
   logic [IdxW-1:0]     sel_idx;
   logic [IdxW-1:0]     cand;
   logic                take;
   logic                accept;
   logic                cpl_ok;

   always_comb begin
      for (int p = 0; p < NumPorts; p++) begin
         elig[p] = req_valid_i[p] && (int'(cnt_q[p]) < MaxTxnsPerPort)
                   && (int'(total_q) < MaxTxns);
      end
   end

   // Scan starts at rr_q and wraps, so the first hit is the round-robin winner.
   always_comb begin
      sel_found = 1'b0;
      sel_idx   = '0;
      cand      = '0;
      for (int i = 0; i < NumPorts; i++) begin
         cand = IdxW'((int'(rr_q) + i) % NumPorts);
         if (!sel_found && elig[cand]) begin
            sel_found = 1'b1;
            sel_idx   = cand;
         end
      end
   end

   assign take        = (state_q == IDLE) && !drain_i && sel_found;
   assign req_ready_o = (rst_ni && take) ? (NumPorts'(1) << sel_idx) : '0;
   assign accept      = (state_q == HOLD) && gnt_ready_i;
   assign cpl_ok      = cpl_valid_i && (int'(cpl_idx_i) < NumPorts) && (cnt_q[cpl_idx_i] != '0);

   // Increment then decrement, so a same-port accept and completion cancel out.
   always_comb begin
      for (int p = 0; p < NumPorts; p++) cnt_d[p] = cnt_q[p];
      total_d = total_q;
      if (accept) begin
         cnt_d[gnt_idx_q] = cnt_d[gnt_idx_q] + CntW'(1);
         total_d          = total_d + CntW'(1);
      end
      if (cpl_ok) begin
         cnt_d[cpl_idx_i] = cnt_d[cpl_idx_i] - CntW'(1);
         total_d          = total_d - CntW'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int p = 0; p < NumPorts; p++) cnt_q[p] <= '0;
         total_q <= '0;
         err_q   <= 1'b0;
      end else begin
         for (int p = 0; p < NumPorts; p++) cnt_q[p] <= cnt_d[p];
         total_q <= total_d;
         err_q   <= cpl_valid_i && !cpl_ok;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= IDLE;
         rr_q        <= '0;
         gnt_valid_q <= 1'b0;
         gnt_idx_q   <= '0;
         gnt_write_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (drain_i) begin
                  state_q <= DRAIN;
               end else if (sel_found) begin
                  state_q     <= HOLD;
                  gnt_valid_q <= 1'b1;
                  gnt_idx_q   <= sel_idx;
                  gnt_write_q <= req_write_i[sel_idx];
               end
            end
            HOLD: begin
               if (gnt_ready_i) begin
                  gnt_valid_q <= 1'b0;
                  rr_q        <= (int'(gnt_idx_q) == NumPorts - 1) ? '0 : gnt_idx_q + 1'b1;
                  state_q     <= drain_i ? DRAIN : IDLE;
               end
            end
            DRAIN: begin
               if (!drain_i) state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign gnt_valid_o = gnt_valid_q;
   assign gnt_idx_o   = gnt_idx_q;
   assign gnt_write_o = gnt_write_q;
   assign err_o       = err_q;
   assign drained_o   = (state_q == DRAIN) && (total_q == '0);

`ifdef SLINK_ARB_STATS_EN
   logic [NumPorts-1:0][31:0] grant_cnt_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         grant_cnt_q <= '0;
      end else if (accept && (grant_cnt_q[gnt_idx_q] != 32'hFFFF_FFFF)) begin
         grant_cnt_q[gnt_idx_q] <= grant_cnt_q[gnt_idx_q] + 32'd1;
      end
   end

   assign grant_cnt_o = grant_cnt_q;
`else
   assign grant_cnt_o = '0;
`endif

endmodule

// File: doc/slink_txn_arbiter.md
SLINK_TXN_ARBITER -- requirements
Module: slink_txn_arbiter

Interface
REQ-001 Parameter NumPorts, default 4: number of external virtual AXI requesters sharing the serial link.
REQ-002 Parameter MaxTxnsPerPort, default 4: outstanding-transaction cap per port.
REQ-003 Parameter MaxTxns, default 8: global outstanding-transaction cap on the link.
REQ-004 clk_i  in  1  system clock; the block has one clock.
REQ-005 rst_ni  in  1  asynchronous, active-low reset.
REQ-006 req_valid_i  in  NumPorts  per-port transaction request (AW or AR head).
REQ-007 req_write_i  in  NumPorts  per-port request type: 1 = write, 0 = read.
REQ-008 req_ready_o  out  NumPorts  one-hot accept; a request is taken when req_valid_i[p] and req_ready_o[p] are both high.
REQ-009 gnt_valid_o  out  1  granted transaction pending toward the link.
REQ-010 gnt_idx_o  out  $clog2(NumPorts)  port index of the granted transaction.
REQ-011 gnt_write_o  out  1  type of the granted transaction.
REQ-012 gnt_ready_i  in  1  link accepts the grant.
REQ-013 cpl_valid_i  in  1  one transaction completed (last R beat or B).
REQ-014 cpl_idx_i  in  $clog2(NumPorts)  port of the completed transaction.
REQ-015 drain_i  in  1  level request to stop granting and empty the link.
REQ-016 drained_o  out  1  high when in DRAIN and the global count is 0.
REQ-017 err_o  out  1  one-cycle pulse on a protocol error.
REQ-018 grant_cnt_o  out  NumPorts x 32  per-port accepted-grant counters.

Function
REQ-019 States: IDLE (no grant held), HOLD (grant registered, waiting gnt_ready_i), DRAIN (no new grants).
REQ-020 Port p is eligible when req_valid_i[p], cnt[p] < MaxTxnsPerPort and total < MaxTxns.
REQ-021 In IDLE with drain_i low, the first eligible port at or after rr_ptr (wrapping at NumPorts-1 to 0) is selected; req_ready_o of that port only is high in the same cycle; next cycle the state is HOLD and gnt_valid_o/gnt_idx_o/gnt_write_o show the registered selection (latency 1 cycle).
REQ-022 In HOLD, gnt_* outputs stay stable until gnt_ready_i; on gnt_ready_i: cnt[gnt_idx]++, total++, rr_ptr = gnt_idx+1 mod NumPorts, state IDLE; no back-to-back grant in the same cycle.
REQ-023 req_ready_o is all-zero in HOLD and DRAIN.
REQ-024 cpl_valid_i decrements cnt[cpl_idx_i] and total in any state.
REQ-025 Grant acceptance and completion on the same port in the same cycle leave that port's and the global counters unchanged.
REQ-026 Completion when cnt[cpl_idx_i] == 0 or cpl_idx_i >= NumPorts: counters unchanged, err_o pulses 1 cycle.
REQ-027 drain_i high in IDLE: transition to DRAIN; in HOLD: complete the held grant first, then DRAIN.
REQ-028 DRAIN exits to IDLE when drain_i is low; drained_o = (state == DRAIN) && total == 0.
REQ-029 Counters are width $clog2(MaxTxns+1) and never wrap (guarded by REQ-020, REQ-026).

Reset
REQ-030 On rst_ni low, asynchronously: state IDLE, rr_ptr 0, all counters 0, req_ready_o 0, gnt_valid_o 0, gnt_idx_o 0, gnt_write_o 0, drained_o 0, err_o 0, grant_cnt_o 0.
REQ-031 Reset mid-HOLD drops the held grant without a completion; no err_o is raised afterwards for it.

Configuration
REQ-032 Macro SLINK_ARB_STATS_EN defined: grant_cnt_o[p] increments by 1 on each accepted grant of port p, saturating at 32'hFFFF_FFFF.
REQ-033 Macro SLINK_ARB_STATS_EN undefined: grant_cnt_o is constant 0 and no counter registers are instantiated.

Verification
REQ-034 Ports 0..3 all valid, gnt_ready_i always 1 -> grants in order 0,1,2,3,0 with one grant every 2 cycles.
REQ-035 Port 1 valid, no completions, MaxTxnsPerPort=4 -> exactly 4 grants to port 1, then req_ready_o[1] stays 0; a single cpl_idx_i=1 re-enables 1 further grant.
REQ-036 gnt_ready_i held low 5 cycles in HOLD -> gnt_idx_o/gnt_write_o unchanged for all 5 cycles and req_ready_o all-zero.
REQ-037 3 outstanding, drain_i=1 -> no new grants; drained_o rises the cycle after the 3rd completion.
REQ-038 cpl_valid_i with cpl_idx_i=2 while cnt[2]=0 -> err_o pulses 1 cycle, total unchanged.
REQ-039 With SLINK_ARB_STATS_EN defined, 10 grants to port 0 -> grant_cnt_o[0] = 10; rst_ni pulse -> 0.
